// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and state encoding for the multiplexed seven-segment scanner.
package display_scan_ctrl_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam int DIV_SIM   = 4;
  localparam int DIV_BOARD = 50000;

  typedef enum logic {
    SCAN    = 1'b0,
    PENDING = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load/ready handshake carrying a packed BCD display value into the scanner.
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);

  logic                    load;
  logic [4*N_DIGITS-1:0]   valor;
  logic                    ready;

  modport master (output load, output valor, input  ready);
  modport slave  (input  load, input  valor, output ready);

endinterface

// File: rtl/display_scan_ctrl_tick_gen.sv
// Refresh counter: runs 0..DIV-1 and flags the last count as a one-cycle tick.
module tick_gen #(
  parameter int DIV = 50000,
  parameter int CW  = 16
) (
  input  logic clock,
  input  logic resetn,
  output logic o_tick
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans N_DIGITS BCD digits onto a shared decoder; new values are double-buffered
// and swapped in only at a frame boundary so a frame never mixes two values.
//
//   state   | meaning
//   SCAN    | ready=1, shadow free; a load captures valor into shadow
//   PENDING | ready=0, shadow holds a value waiting for the next frame end
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  parameter int CW       = 16
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 blank_zero,
  display_scan_ctrl_if.slave   bus,
  output logic [3:0]           bcd,
  output logic [N_DIGITS-1:0]  an,
  output logic                 frame
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

  logic                  w_tick;
  logic                  w_frame_end;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_active;
  logic [4*N_DIGITS-1:0] r_shadow;
  scan_state_t           r_state;
  logic                  r_en;
  logic                  r_bz;
  logic                  r_frame;

  logic [3:0]            w_digit [N_DIGITS];
  logic [N_DIGITS-1:0]   w_upper_zero;
  logic [N_DIGITS-1:0]   w_an;
  logic [3:0]            w_bcd;

  tick_gen #(.DIV(DIV), .CW(CW)) u_tick_gen (
    .clock  (clock),
    .resetn (resetn),
    .o_tick (w_tick)
  );

  assign w_frame_end = w_tick && (r_idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_idx    <= '0;
      r_active <= '0;
      r_shadow <= '0;
      r_state  <= SCAN;
      r_en     <= 1'b0;
      r_bz     <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_en    <= enable;
      r_bz    <= blank_zero;
      r_frame <= w_frame_end;
      if (w_tick) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      case (r_state)
        SCAN: begin
          // A load landing on a frame end waits for the following frame end.
          if (bus.load) begin
            r_shadow <= bus.valor;
            r_state  <= PENDING;
          end
        end
        PENDING: begin
          if (w_frame_end) begin
            r_active <= r_shadow;
            r_state  <= SCAN;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  // w_upper_zero[i] is set when digits i..N_DIGITS-1 are all zero.
  always_comb begin : lz_mask
    logic w_all_zero;
    w_all_zero   = 1'b1;
    w_upper_zero = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_digit[i] = r_active[4*i +: 4];
    end
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_all_zero      = w_all_zero && (w_digit[i] == 4'h0);
      w_upper_zero[i] = w_all_zero;
    end
  end

  always_comb begin
    w_an  = '1;
    w_bcd = BLANK_CODE;
    if (r_en) begin
      w_an[r_idx] = 1'b0;
      if (r_bz && (r_idx != '0) && w_upper_zero[r_idx]) begin
        w_bcd = BLANK_CODE;
      end else begin
        w_bcd = w_digit[r_idx];
      end
    end
  end

  assign an        = w_an;
  assign bcd       = w_bcd;
  assign frame     = r_frame;
  assign bus.ready = (r_state == SCAN);

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes N_DIGITS BCD digits onto one shared BCD-to-seven-segment decoder and one common segment bus.
- Generates a refresh tick, walks a one-hot active-low digit enable, and presents the selected nibble to the decoder.
- Accepts new display values through a load/ready handshake. New values are double-buffered and applied only at a frame boundary, so the display never tears.
- Sits between the datapath (counter/ALU result) and the board's multiplexed 7-segment display.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 50000, clock cycles per digit slot (≥2).
- CW, 16, refresh counter width; must satisfy 2^CW ≥ DIV.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  1 = display on; 0 = all digits dark.
- blank_zero  in  1  1 = suppress leading zeros.
- load  in  1  request to load valor.
- valor  in  4*N_DIGITS  packed BCD digits; digit 0 = bits [3:0] (rightmost).
- ready  out  1  1 = load is accepted this cycle.
- bcd  out  4  nibble to the shared decoder; 4'hF = blank (the decoder drives all segments off for codes 10..15).
- an  out  N_DIGITS  digit enables, active-low, one-hot-zero or all ones.
- frame  out  1  one-cycle pulse at each frame end.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - cnt=0, idx=0, active=0, shadow=0, state=SCAN, en_r=0, bz_r=0.
  - Outputs in the following cycle: an=all ones, bcd=4'hF, ready=1, frame=0.
  - Reset mid-operation discards any pending value.
- Refresh counter:
  - cnt runs 0..DIV-1 and wraps to 0.
  - tick = (cnt==DIV-1).
- Digit index:
  - On tick, idx increments; it wraps from N_DIGITS-1 to 0.
  - frame_end = tick && idx==N_DIGITS-1.
  - frame is registered and equals frame_end delayed one cycle.
- en_r and bz_r register enable and blank_zero every cycle, so these inputs take effect with one cycle of latency.
- Output decode (combinational from registers only):
  - If en_r=0: an=all ones, bcd=4'hF.
  - Otherwise an[idx]=0 and all other bits are 1.
  - bcd = active digit idx, except it is forced to 4'hF when bz_r=1, idx>0, and active digits idx..N_DIGITS-1 are all zero.
  - Digit 0 is never zero-blanked.
  - Non-BCD digits (A..F) pass through unchanged; the decoder displays them as blank.
- Handshake FSM, two states:
  - SCAN: ready=1. load=1 → shadow<=valor, go to PENDING.
  - PENDING: ready=0; load is ignored. On frame_end → active<=shadow, go to SCAN.
- Boundary cases:
  - load accepted on the same edge as a frame_end in SCAN: value goes to shadow and is applied at the NEXT frame_end, not the current one.
  - load while ready=0: dropped with no side effect; the requester must hold load until ready=1.
  - Scanning continues in both states; the handshake never stalls the refresh.
  - active changes only on a frame_end edge, so every frame shows one coherent value.
- Worst-case load-to-display latency: 2 frames (2·N_DIGITS·DIV cycles).

Decomposition:
- Shared package (display_pkg):
  - BLANK_CODE = 4'hF.
  - State encoding constants: SCAN=1'b0, PENDING=1'b1.
  - Default DIV constants for simulation (4) and board (50000).
- Sub-module tick_gen (parameter DIV): refresh counter producing a one-cycle tick, synchronous active-low reset.
- Leading-zero mask, FSM and output decode live in display_scan_ctrl.

Test Plan (N_DIGITS=4, DIV=4):
- Reset, enable=1, blank_zero=0, no load → an cycles 1110,1101,1011,0111, each held 4 cycles; bcd=0 throughout; frame pulses every 16 cycles.
- load=1, valor=16'h1234 mid-frame → ready falls next cycle; after the next frame boundary, digit slots show bcd 4,3,2,1 with an 1110..0111; ready returns to 1.
- valor=16'h0042, blank_zero=1 → bcd sequence 2,4,F,F per frame; with blank_zero=0 → 2,4,0,0.
- Two loads (16'h1111, then 16'h2222 while ready=0) → only 1111 is displayed; 2222 is never shown unless re-issued after ready=1.
- load coincident with a frame_end edge → old value persists for one more full frame, then the new value is shown.
- enable=0 during a scan → an=1111 and bcd=F one cycle after the input change, while idx keeps advancing; resetn=0 while PENDING → pending value lost, display returns to 0.
